wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Parametrised writeback arbiter between N result producers (ALU and future functional units) and the register-file write port.
- Each channel has an independent four-phase req/ack handshake feeding a per-channel queue.
- A round-robin arbiter drains the queues into a single four-phase write transaction toward the register file.
- Successor to the single-channel writeback stage: adds channel count, buffering, fairness and r0 write suppression.

Parameters:
- NUM_CH, 2, number of producer channels (1..8)
- DATA_W, 16, write data width
- ADDR_W, 4, register address width
- FIFO_DEPTH, 2, entries per channel queue (power of two, >=2)
- DROP_R0, 1, when 1, entries addressed to register 0 are popped with no register-file transaction

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- ch_req  in  NUM_CH  per-channel request, level, four-phase
- ch_ack  out  NUM_CH  per-channel acknowledge
- ch_addr  in  NUM_CH*ADDR_W  destination register; channel i occupies bits [i*ADDR_W +: ADDR_W]
- ch_data  in  NUM_CH*DATA_W  result data, packed the same way
- ch_full  out  NUM_CH  channel queue full (status)
- rf_req  out  1  write request to register file
- rf_ack  in  1  register-file acknowledge
- rf_we  out  1  write enable; equals rf_req
- rf_addr  out  ADDR_W  write address
- rf_data  out  DATA_W  write data
- rf_ch  out  $clog2(NUM_CH) (min 1)  channel that owns the current write
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset: all outputs 0, queues empty, every FSM idle, rr pointer = NUM_CH-1 (so channel 0 wins first). Reset mid-transaction abandons it immediately: rf_req and ch_ack drop on the next edge, and queued data is discarded.
- Upstream FSM, one per channel, states U_IDLE, U_ACK:
  - U_IDLE: if ch_req=1 and queue not full, push {addr,data} and go to U_ACK; ch_ack=1 from the next cycle, i.e. 1-cycle latency.
  - U_IDLE with ch_req=1 and queue full: no push, ch_ack stays 0 until space appears.
  - U_ACK: hold ch_ack=1 until ch_req=0, then go to U_IDLE with ch_ack=0 on the next cycle. Exactly one push per handshake.
  - Producer holds addr/data stable while ch_req=1 and ch_ack=0.
- Downstream FSM, states D_IDLE, D_REQ, D_REL:
  - D_IDLE: if any queue is non-empty, grant the first non-empty channel searching from rr+1 modulo NUM_CH, and update rr to the granted channel.
  - D_IDLE with DROP_R0=1 and granted head addr==0: pop the head and stay in D_IDLE; no rf_req, and the next grant can occur next cycle.
  - D_IDLE otherwise: register head addr/data/channel onto rf_addr/rf_data/rf_ch, then go to D_REQ with rf_req=1 next cycle.
  - D_REQ: rf_addr/rf_data/rf_ch held stable. When rf_ack=1, pop the granted queue, set rf_req=0, go to D_REL.
  - D_REL: when rf_ack=0, go to D_IDLE.
  - Minimum 4 cycles per write.
- Push and pop on the same queue in the same cycle are both honoured and the count is unchanged. A full queue with a same-cycle pop does not accept the push that cycle; it accepts it the cycle after.
- Queue pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1. ch_full = (count==FIFO_DEPTH).
- proto_err is set, and stays set until rst, when any of these occurs:
  - rf_ack=1 while in D_IDLE
  - ch_req falls while that channel is in U_IDLE and its ch_ack=1
- Ordering: FIFO order is preserved within a channel. There is no ordering guarantee across channels.

Decomposition:
- Package wb_arb_pkg:
  - upstream state enum u_state_t {U_IDLE, U_ACK}
  - downstream state enum d_state_t {D_IDLE, D_REQ, D_REL}
  - localparam helper for the channel-index width
- Sub-module hs_fifo: parametrised DATA_W/DEPTH synchronous FIFO with push, pop, full, empty and count; instantiated NUM_CH times with width ADDR_W+DATA_W.

Test Plan:
- Single write: ch0 req with addr=3, data=0x1234 → ch_ack[0]=1 one cycle later; rf_req=1 with rf_addr=3, rf_data=0x1234, rf_ch=0; rf_ack pulse → rf_req drops; ch0 queue empty.
- Round-robin: ch0 and ch1 each queue 2 entries (addr 1,2 and 5,6), then rf_ack is answered 1 cycle after each rf_req → write order is 1,5,2,6.
- Backpressure: rf_ack held 0, ch0 sends 3 handshakes with FIFO_DEPTH=2 → first two acked and ch_full[0]=1; third req stays unacked; after one rf_ack cycle, third req is acked within 2 cycles.
- r0 drop: ch1 sends addr=0, data=0xFFFF, then addr=7, data=0x0001 → no rf_req for addr 0; the single rf transaction carries addr=7. With DROP_R0=0, two transactions occur.
- Reset mid-write: rst asserted in D_REQ with 1 entry still queued → next cycle rf_req=0, ch_ack=0, ch_full=0; after release, no rf_req without new input.
- Protocol error: rf_ack=1 while idle → proto_err=1 and stays 1 until rst; no queue is popped.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback arbiter: handshake state encodings and the
// helper that sizes channel-index fields.
package wb_arb_pkg;

  typedef enum logic {U_IDLE, U_ACK} u_state_t;

  typedef enum logic [1:0] {D_IDLE, D_REQ, D_REL} d_state_t;

  localparam int MIN_IDX_W = 1;

  // A single-channel build still needs a 1-bit index field.
  function automatic int chIdxW(input int n);
    return (n > 1) ? $clog2(n) : MIN_IDX_W;
  endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Per-channel synchronous queue: the head is always visible on o_data, and a
// push into a full queue is refused even when a pop happens in the same cycle.
module hs_fifo #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [DATA_W-1:0]      i_data,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              w_doPush;
  logic              w_doPop;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-channel four-phase producers feed queues that a
// round-robin grant drains into one four-phase register-file write port.
module wb_arbiter import wb_arb_pkg::*; #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int DROP_R0    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_req,
  output logic [NUM_CH-1:0]          ch_ack,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic [NUM_CH-1:0]          ch_full,
  output logic                       rf_req,
  input  logic                       rf_ack,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_addr,
  output logic [DATA_W-1:0]          rf_data,
  output logic [chIdxW(NUM_CH)-1:0]  rf_ch,
  output logic                       proto_err
);

  localparam int CH_W  = chIdxW(NUM_CH);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  u_state_t          r_uState [NUM_CH];
  logic [NUM_CH-1:0] r_ack;
  logic [NUM_CH-1:0] r_reqPrev;
  logic [NUM_CH-1:0] w_uIdle;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [ENT_W-1:0]  w_head  [NUM_CH];
  logic [CNT_W-1:0]  w_count [NUM_CH];

  d_state_t          r_dState;
  logic [CH_W-1:0]   r_rr;
  logic [CH_W-1:0]   r_grant;
  logic              r_rfReq;
  logic [ADDR_W-1:0] r_rfAddr;
  logic [DATA_W-1:0] r_rfData;
  logic              r_protoErr;

  logic              w_found;
  logic [CH_W-1:0]   w_grantIdx;
  logic [CH_W-1:0]   w_cand;
  logic [ADDR_W-1:0] w_headAddr;
  logic [DATA_W-1:0] w_headData;
  logic              w_dropHead;
  logic              w_ackErr;
  logic              w_reqErr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hs_fifo #(
      .DATA_W (ENT_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_data  ({ch_addr[g*ADDR_W +: ADDR_W], ch_data[g*DATA_W +: DATA_W]}),
      .o_data  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_count (w_count[g])
    );

    assign w_uIdle[g] = (r_uState[g] == U_IDLE);
    assign w_push[g]  = w_uIdle[g] && ch_req[g] && !w_full[g];
    assign ch_full[g] = (w_count[g] == CNT_W'(FIFO_DEPTH));
  end

  // Upstream: one push per handshake, ack held until the producer releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) r_uState[i] <= U_IDLE;
      r_ack     <= '0;
      r_reqPrev <= '0;
    end else begin
      r_reqPrev <= ch_req;
      for (int i = 0; i < NUM_CH; i++) begin
        case (r_uState[i])
          U_IDLE: if (w_push[i]) begin
            r_uState[i] <= U_ACK;
            r_ack[i]    <= 1'b1;
          end
          U_ACK: if (!ch_req[i]) begin
            r_uState[i] <= U_IDLE;
            r_ack[i]    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Round-robin search starts one past the last granted channel.
  always_comb begin
    w_found    = 1'b0;
    w_grantIdx = '0;
    w_cand     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_cand = CH_W'((int'(r_rr) + k) % NUM_CH);
      if (!w_found && !w_empty[w_cand]) begin
        w_found    = 1'b1;
        w_grantIdx = w_cand;
      end
    end
  end

  assign w_headAddr = w_head[w_grantIdx][ENT_W-1 -: ADDR_W];
  assign w_headData = w_head[w_grantIdx][DATA_W-1:0];
  assign w_dropHead = (DROP_R0 != 0) && (r_dState == D_IDLE) && w_found &&
                      (w_headAddr == '0);

  always_comb begin
    w_pop = '0;
    if (w_dropHead) begin
      w_pop[w_grantIdx] = 1'b1;
    end else if (r_dState == D_REQ && rf_ack) begin
      w_pop[r_grant] = 1'b1;
    end
  end

  assign w_ackErr = (r_dState == D_IDLE) && rf_ack;
  assign w_reqErr = |(r_reqPrev & ~ch_req & w_uIdle & r_ack);

  // Downstream: the queue entry is popped only once the register file acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dState   <= D_IDLE;
      r_rr       <= CH_W'(NUM_CH - 1);
      r_grant    <= '0;
      r_rfReq    <= 1'b0;
      r_rfAddr   <= '0;
      r_rfData   <= '0;
      r_protoErr <= 1'b0;
    end else begin
      if (w_ackErr || w_reqErr) r_protoErr <= 1'b1;
      case (r_dState)
        D_IDLE: if (w_found) begin
          r_rr <= w_grantIdx;
          if (!w_dropHead) begin
            r_grant  <= w_grantIdx;
            r_rfAddr <= w_headAddr;
            r_rfData <= w_headData;
            r_rfReq  <= 1'b1;
            r_dState <= D_REQ;
          end
        end
        D_REQ: if (rf_ack) begin
          r_rfReq  <= 1'b0;
          r_dState <= D_REL;
        end
        D_REL: if (!rf_ack) r_dState <= D_IDLE;
        default: r_dState <= D_IDLE;
      endcase
    end
  end

  assign ch_ack    = r_ack;
  assign rf_req    = r_rfReq;
  assign rf_we     = r_rfReq;
  assign rf_addr   = r_rfAddr;
  assign rf_data   = r_rfData;
  assign rf_ch     = r_grant;
  assign proto_err = r_protoErr;

endmodule
